// File: rtl/pong_pkg.sv
// Shared Pong definitions: game/ball/mode codes, ball-engine FSM states,
// debug view and default playfield geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    GS_START = 2'b00,
    GS_SERVE = 2'b01,
    GS_PLAY  = 2'b10,
    GS_DONE  = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    BS_PLAYING = 2'b00,
    BS_P1WIN   = 2'b01,
    BS_P2WIN   = 2'b10
  } ball_status_t;

  typedef enum logic [1:0] {
    MODE_PVP      = 2'b00,
    MODE_P_VS_AI  = 2'b01,
    MODE_AI_VS_AI = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_STEP,
    ST_COLLIDE,
    ST_REPORT,
    ST_OUT
  } ball_fsm_t;

  typedef struct packed {
    ball_fsm_t  state;
    logic [7:0] lfsr;
    logic       dir_right;
    logic       dir_down;
    logic [3:0] dy_mag;
  } ball_dbg_t;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PADDLE_W  = 8;
  localparam int DEF_PADDLE_H  = 64;
  localparam int DEF_P1_X      = 16;
  localparam int DEF_P2_X      = 616;
  localparam int DEF_SPEED_X   = 4;
  localparam int DEF_MAX_DY    = 6;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/ball_engine_if.sv
// Ball engine bus: game-FSM and paddle inputs, ball position and status outputs.
interface ball_engine_if;
  import pong_pkg::*;

  // frame_tick is a one-cycle strobe with no backpressure: the engine takes it
  // only while idle between frames and drops it otherwise.
  logic         frame_tick;
  game_state_t  game_state;
  logic         serve;
  logic [9:0]   paddle1_y;
  logic [9:0]   paddle2_y;
  logic [9:0]   ball_x;
  logic [9:0]   ball_y;
  ball_status_t ball_status;

  modport master (
    output frame_tick, game_state, serve, paddle1_y, paddle2_y,
    input  ball_x, ball_y, ball_status
  );

  modport slave (
    input  frame_tick, game_state, serve, paddle1_y, paddle2_y,
    output ball_x, ball_y, ball_status
  );

endinterface

// File: rtl/pong_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running, seeded on reset.
module pong_lfsr8
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  always_ff @(posedge clk) begin
    if (rst) out <= LFSR_SEED;
    else     out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
  end

endmodule

// File: rtl/ball_engine.sv
// Frame-stepped Pong ball: move, collide against walls/paddles, report exits.
module ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PADDLE_W  = DEF_PADDLE_W,
  parameter int PADDLE_H  = DEF_PADDLE_H,
  parameter int P1_X      = DEF_P1_X,
  parameter int P2_X      = DEF_P2_X,
  parameter int SPEED_X   = DEF_SPEED_X,
  parameter int MAX_DY    = DEF_MAX_DY
) (
  input  logic          clk,
  input  logic          rst,
  ball_engine_if.slave  bus,
  output ball_dbg_t     dbg
);

  localparam logic [9:0] CENTER_X    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] CENTER_Y    = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] X_LIMIT     = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] Y_LIMIT     = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] P1_BOUNCE_X = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] P2_BOUNCE_X = 10'(P2_X - BALL_SIZE);
  localparam logic [3:0] DY_MAX      = 4'(MAX_DY);

  localparam logic signed [10:0] STEP_X    = 11'(SPEED_X);
  localparam logic signed [11:0] X_LIM_S   = 12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] Y_LIM_S   = 12'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] P1_LEFT   = 12'(P1_X);
  localparam logic signed [11:0] P1_RIGHT  = 12'(P1_X + PADDLE_W);
  localparam logic signed [11:0] P2_LEFT   = 12'(P2_X);
  localparam logic signed [11:0] P2_RIGHT  = 12'(P2_X + PADDLE_W);
  localparam logic signed [11:0] BALL_S    = 12'(BALL_SIZE);
  localparam logic signed [11:0] PAD_H_S   = 12'(PADDLE_H);
  localparam logic signed [11:0] BALL_HALF = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] PAD_HALF  = 12'(PADDLE_H / 2);
  localparam logic signed [11:0] DY_MAX_S  = 12'(MAX_DY);

  ball_fsm_t         state_q, state_d;
  logic [7:0]        lfsr;
  logic [9:0]        x_q, y_q;
  logic signed [10:0] xn_q, yn_q, x_cur, y_cur, dy_step;
  logic              dir_right, dir_down;
  logic [3:0]        dy_mag, dy_new;
  ball_status_t      pending;
  logic              hold_load, p1_hit, p2_hit, top_hit, bot_hit;
  logic signed [11:0] xw, yw, p1w, p2w, pw, off, off_abs, mag;

  pong_lfsr8 u_lfsr (.clk(clk), .rst(rst), .out(lfsr));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HOLD;
    else     state_q <= state_d;
  end

  // Next state: leaving PLAY always wins, from any state
  always_comb begin
    state_d = state_q;
    if (bus.game_state != GS_PLAY) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD:    state_d = ST_WAIT;
        ST_WAIT:    if (bus.frame_tick) state_d = ST_STEP;
        ST_STEP:    state_d = ST_COLLIDE;
        ST_COLLIDE: state_d = ST_REPORT;
        ST_REPORT:  state_d = (pending != BS_PLAYING) ? ST_OUT : ST_WAIT;
        ST_OUT:     state_d = ST_OUT;
        default:    state_d = ST_HOLD;
      endcase
    end
  end

  // Outputs: status is only driven from the registered pending result in REPORT
  always_comb begin
    bus.ball_status = BS_PLAYING;
    if (state_q == ST_REPORT) bus.ball_status = pending;
  end

  assign bus.ball_x = x_q;
  assign bus.ball_y = y_q;
  assign dbg = '{state: state_q, lfsr: lfsr, dir_right: dir_right,
                 dir_down: dir_down, dy_mag: dy_mag};

  assign x_cur   = signed'({1'b0, x_q});
  assign y_cur   = signed'({1'b0, y_q});
  assign dy_step = signed'({7'b0, dy_mag});
  assign xw      = {xn_q[10], xn_q};
  assign yw      = {yn_q[10], yn_q};
  assign p1w     = {2'b00, bus.paddle1_y};
  assign p2w     = {2'b00, bus.paddle2_y};

  assign p1_hit  = !dir_right && (xw <= P1_RIGHT) && (xw + BALL_S > P1_LEFT) &&
                   (yw + BALL_S > p1w) && (yw < p1w + PAD_H_S);
  assign p2_hit  = dir_right && (xw + BALL_S >= P2_LEFT) && (xw < P2_RIGHT) &&
                   (yw + BALL_S > p2w) && (yw < p2w + PAD_H_S);
  assign top_hit = (yw <= 12'sd0);
  assign bot_hit = (yw >= Y_LIM_S);

  // Bounce angle from where the ball centre meets the paddle centre
  always_comb begin
    pw      = p1_hit ? p1w : p2w;
    off     = (yw + BALL_HALF) - (pw + PAD_HALF);
    off_abs = off[11] ? -off : off;
    mag     = off_abs >>> 3;
    if (mag > DY_MAX_S)       dy_new = DY_MAX;
    else if (mag == 12'sd0)   dy_new = 4'd1;
    else                      dy_new = mag[3:0];
  end

  assign hold_load = (bus.game_state != GS_PLAY) || (state_q == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= CENTER_X;
      y_q       <= CENTER_Y;
      xn_q      <= '0;
      yn_q      <= '0;
      dir_right <= 1'b1;
      dir_down  <= 1'b1;
      dy_mag    <= 4'd1;
      pending   <= BS_PLAYING;
    end else if (hold_load) begin
      x_q       <= CENTER_X;
      y_q       <= CENTER_Y;
      dir_right <= !bus.serve;
      dir_down  <= lfsr[0];
      dy_mag    <= 4'd1;
      pending   <= BS_PLAYING;
    end else begin
      case (state_q)
        ST_STEP: begin
          xn_q <= dir_right ? x_cur + STEP_X : x_cur - STEP_X;
          yn_q <= dir_down  ? y_cur + dy_step : y_cur - dy_step;
        end
        ST_COLLIDE: begin
          pending <= BS_PLAYING;
          if (p1_hit || p2_hit) begin
            x_q       <= p1_hit ? P1_BOUNCE_X : P2_BOUNCE_X;
            dir_right <= p1_hit;
            dy_mag    <= dy_new;
            if (off > 12'sd0)      dir_down <= 1'b1;
            else if (off < 12'sd0) dir_down <= 1'b0;
          end else if (xw <= 12'sd0) begin
            x_q     <= '0;
            pending <= BS_P2WIN;
          end else if (xw >= X_LIM_S) begin
            x_q     <= X_LIMIT;
            pending <= BS_P1WIN;
          end else begin
            x_q <= xn_q[9:0];
          end
          // Wall bounce is assigned last so it overrides a paddle's dir_y
          if (top_hit) begin
            y_q      <= '0;
            dir_down <= 1'b1;
          end else if (bot_hit) begin
            y_q      <= Y_LIMIT;
            dir_down <= 1'b0;
          end else begin
            y_q <= yn_q[9:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with a per-frame reference model and scoreboard.
module tb_ball_engine;
  import pong_pkg::*;

  logic      clk;
  logic      rst;
  ball_dbg_t dbg;
  ball_engine_if bus ();

  ball_engine dut (.clk(clk), .rst(rst), .bus(bus), .dbg(dbg));

  // Clock and reference LFSR
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Scoreboard: {status, x, y}
  logic [21:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference ball state
  int m_x, m_y, m_dy;
  bit m_dxr, m_dyd, m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [21:0] model_frame();
    int xn, yn, off, a, py, p1, p2;
    bit h1, h2;
    logic [1:0] st;
    st = 2'b00;
    if (m_over) return {st, 10'(m_x), 10'(m_y)};
    p1 = int'(bus.paddle1_y);
    p2 = int'(bus.paddle2_y);
    xn = m_dxr ? m_x + 4 : m_x - 4;
    yn = m_dyd ? m_y + m_dy : m_y - m_dy;
    h1 = !m_dxr && xn <= 24 && xn + 8 > 16 && yn + 8 > p1 && yn < p1 + 64;
    h2 = m_dxr && xn + 8 >= 616 && xn < 624 && yn + 8 > p2 && yn < p2 + 64;
    if (h1 || h2) begin
      py   = h1 ? p1 : p2;
      off  = (yn + 4) - (py + 32);
      a    = (off < 0 ? -off : off) / 8;
      m_dy = (a > 6) ? 6 : ((a < 1) ? 1 : a);
      if (off > 0) m_dyd = 1'b1;
      else if (off < 0) m_dyd = 1'b0;
      m_dxr = h1;
      xn = h1 ? 24 : 608;
    end else if (xn <= 0) begin
      st = 2'b10; xn = 0; m_over = 1'b1;
    end else if (xn >= 632) begin
      st = 2'b01; xn = 632; m_over = 1'b1;
    end
    if (yn <= 0) begin
      yn = 0; m_dyd = 1'b1;
    end else if (yn >= 472) begin
      yn = 472; m_dyd = 1'b0;
    end
    m_x = xn;
    m_y = yn;
    return {st, 10'(xn), 10'(yn)};
  endfunction

  // Driver tasks (all start and end on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_play(input bit srv);
    bus.game_state = GS_SERVE;
    bus.serve      = srv;
    idle(2);
    bus.game_state = GS_PLAY;
    m_x = 316; m_y = 236; m_dy = 1; m_dxr = !srv; m_over = 1'b0;
    m_dyd = lfsr_m[0];
    idle(1);
  endtask

  task automatic frame();
    logic [21:0] exp;
    logic [9:0]  prev_x;
    prev_x = 10'(m_x);
    bus.frame_tick = 1'b1;
    exp_q.push_back(model_frame());
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    check("x_before_report", 32'(bus.ball_x), 32'(prev_x));
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'(0), 32'(1));
    end else begin
      exp = exp_q.pop_front();
      check("frame_x", 32'(bus.ball_x), 32'(exp[19:10]));
      check("frame_y", 32'(bus.ball_y), 32'(exp[9:0]));
      check("frame_status", 32'(bus.ball_status), 32'(exp[21:20]));
    end
    @(negedge clk);
    check("status_one_cycle", 32'(bus.ball_status), 32'(BS_PLAYING));
    idle(4);
  endtask

  initial begin
    int yn, py, tgt_off;
    bit last_dir;

    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.game_state = GS_START;
    bus.serve      = 1'b0;
    bus.paddle1_y  = '0;
    bus.paddle2_y  = '0;
    idle(3);

    // Reset values
    check("rst_x", 32'(bus.ball_x), 32'd316);
    check("rst_y", 32'(bus.ball_y), 32'd236);
    check("rst_status", 32'(bus.ball_status), 32'(BS_PLAYING));
    check("rst_state", 32'(dbg.state), 32'(ST_HOLD));
    check("rst_lfsr", 32'(dbg.lfsr), 32'hA5);
    check("rst_dir", 32'({dbg.dir_right, dbg.dir_down}), 32'b11);
    check("rst_dy", 32'(dbg.dy_mag), 32'd1);
    rst = 1'b0;
    idle(2);

    // Player 1 serves, ball runs right past paddle 2 on the 79th frame
    enter_play(1'b0);
    check("play_wait_state", 32'(dbg.state), 32'(ST_WAIT));
    for (int i = 0; i < 79; i++) frame();
    check("win_ball_x", 32'(bus.ball_x), 32'd632);
    check("out_state", 32'(dbg.state), 32'(ST_OUT));
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    idle(4);
    check("out_frozen_x", 32'(bus.ball_x), 32'd632);
    check("out_status_quiet", 32'(bus.ball_status), 32'(BS_PLAYING));
    check("out_state_held", 32'(dbg.state), 32'(ST_OUT));

    // Player 2 serves; paddle 1 placed for an offset of +4 on the bounce frame
    enter_play(1'b1);
    for (int i = 0; i < 72; i++) frame();
    check("approach_x", 32'(bus.ball_x), 32'd28);
    yn = m_dyd ? m_y + 1 : m_y - 1;
    bus.paddle1_y = 10'(yn - 32);
    frame();
    check("p1_bounce_x", 32'(bus.ball_x), 32'd24);
    check("p1_dir_right", 32'(dbg.dir_right), 32'd1);
    check("p1_dir_down", 32'(dbg.dir_down), 32'd1);
    check("p1_dy_mag", 32'(dbg.dy_mag), 32'd1);

    // Rally: paddles track the ball with a per-approach offset
    tgt_off  = 0;
    last_dir = m_dxr;
    for (int i = 0; i < 450; i++) begin
      if (m_dxr != last_dir) begin
        tgt_off  = int'($urandom_range(70)) - 35;
        last_dir = m_dxr;
      end
      yn = m_dyd ? m_y + m_dy : m_y - m_dy;
      py = clamp(yn + 4 - 32 - tgt_off, 0, 416);
      if (m_dxr) bus.paddle2_y = 10'(py);
      else       bus.paddle1_y = 10'(py);
      frame();
    end

    // Leaving PLAY during COLLIDE recentres the ball and drops the frame
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    bus.game_state = GS_SERVE;
    @(negedge clk);
    check("abort_x", 32'(bus.ball_x), 32'd316);
    check("abort_y", 32'(bus.ball_y), 32'd236);
    check("abort_status", 32'(bus.ball_status), 32'(BS_PLAYING));
    check("abort_state", 32'(dbg.state), 32'(ST_HOLD));
    idle(2);

    // Reset asserted in REPORT
    enter_play(1'b0);
    frame();
    frame();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    idle(2);
    check("report_state", 32'(dbg.state), 32'(ST_REPORT));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_x", 32'(bus.ball_x), 32'd316);
    check("midrst_y", 32'(bus.ball_y), 32'd236);
    check("midrst_status", 32'(bus.ball_status), 32'(BS_PLAYING));
    check("midrst_state", 32'(dbg.state), 32'(ST_HOLD));
    check("midrst_lfsr", 32'(dbg.lfsr), 32'hA5);
    check("midrst_dy", 32'(dbg.dy_mag), 32'd1);
    rst = 1'b0;
    bus.game_state = GS_START;
    idle(2);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
